flit_uart_sequencer: RTL and testbench

Serializes router flits onto the UART byte transmitter, byte by byte, without any pushbutton stepping. Two flit sources compete for the single UART byte path: the router ejection port and the debug capture register. A round-robin arbiter shares the path between them. The block sits between the router/capture logic and `uart_byte_tx`, and drives that transmitter's `send_en` and `data_byte` from a sequencing FSM.

---
 rtl/flit_uart_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 43 ++++
 rtl/flit_uart_sequencer.sv | 165 ++++++++++++++++
 tb/tb_flit_uart_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_uart_pkg.sv
// flit_uart_pkg: shared state type, byte width, default timeout and frame length helper.
// Optional feature macro: FLIT_UART_CHECKSUM_EN (adds a trailing XOR checksum byte).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package flit_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } seq_state_t;

    localparam int BYTE_W                 = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;

    // Number of bytes put on the UART for one flit of width dw
    function automatic int frame_len(input int dw);
`ifdef FLIT_UART_CHECKSUM_EN
        return dw / BYTE_W + 1;
`else
        return dw / BYTE_W;
`endif
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a registered last-grant pointer.
module rr_arb2
    import flit_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_q;
    logic last_grant_d;

    // On contention favour the source that did not win last time; a lone requester always wins
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    // Remember which source won whenever a grant is actually consumed
    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = grant[1];
        end
    end

    // Pointer starts at source 1 so source 0 takes the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/flit_uart_sequencer.sv
// flit_uart_sequencer: arbitrates two flit sources and feeds their flits MSB-byte-first
// to the UART byte transmitter, with a per-byte completion timeout.
// Optional feature macro: FLIT_UART_CHECKSUM_EN (appends XOR of the data bytes).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module flit_uart_sequencer
    import flit_uart_pkg::*;
#(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [2*DATA_WIDTH-1:0] req_data,
    output logic [1:0]              req_ready,
    output logic [7:0]              tx_byte,
    output logic                    tx_send_en,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    cur_src,
    output logic [3:0]              byte_idx,
    output logic                    timeout_err
);

    localparam int         BYTES    = DATA_WIDTH / BYTE_W;
    localparam logic [3:0] LAST_IDX = 4'(frame_len(DATA_WIDTH) - 1);
    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  cur_src_q, cur_src_d;
    logic [3:0]            byte_idx_q, byte_idx_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef FLIT_UART_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic [1:0]            grant;
    logic                  arb_last_grant_unused;
    logic                  accept;
    logic                  accept_src;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef FLIT_UART_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH-1:0] d);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < BYTES; i++) begin
            x ^= d[i*BYTE_W +: BYTE_W];
        end
        return x;
    endfunction
`endif

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid),
        .update     (accept),
        .grant      (grant),
        .last_grant (arb_last_grant_unused)
    );

    assign req_ready  = (state_q == IDLE && !reset) ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign accept_src = req_ready[1];
    assign sel_data   = accept_src ? req_data[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                   : req_data[DATA_WIDTH-1:0];

    // Sequencing FSM: latch a flit, launch one byte, wait for completion or timeout, repeat
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        tx_byte_d     = tx_byte_q;
        cur_src_d     = cur_src_q;
        byte_idx_d    = byte_idx_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        tx_send_en    = 1'b0;
`ifdef FLIT_UART_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = sel_data;
                    tx_byte_d  = sel_data[DATA_WIDTH-1 -: BYTE_W];
                    cur_src_d  = accept_src;
                    byte_idx_d = '0;
`ifdef FLIT_UART_CHECKSUM_EN
                    csum_d     = xor_bytes(sel_data);
`endif
                    state_d    = SEND;
                end
            end
            SEND: begin
                tx_send_en = !reset;
                cnt_d      = CNT_W'(TIMEOUT_CYCLES);
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        shift_d    = {shift_q[DATA_WIDTH-BYTE_W-1:0], shift_q[DATA_WIDTH-1 -: BYTE_W]};
                        tx_byte_d  = shift_q[DATA_WIDTH-BYTE_W-1 -: BYTE_W];
`ifdef FLIT_UART_CHECKSUM_EN
                        if (byte_idx_q == 4'(BYTES - 1)) begin
                            tx_byte_d = csum_q;
                        end
`endif
                        state_d    = SEND;
                    end
                end else if (cnt_q == '0) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            tx_byte_q     <= '0;
            cur_src_q     <= 1'b0;
            byte_idx_q    <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
`ifdef FLIT_UART_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            tx_byte_q     <= tx_byte_d;
            cur_src_q     <= cur_src_d;
            byte_idx_q    <= byte_idx_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
`ifdef FLIT_UART_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign tx_byte     = tx_byte_q;
    assign busy        = (state_q != IDLE);
    assign cur_src     = cur_src_q;
    assign byte_idx    = byte_idx_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_flit_uart_sequencer.sv
// tb_flit_uart_sequencer: directed, table-driven bench for flit_uart_sequencer
// (32-bit flits, 20-cycle timeout). Honours FLIT_UART_CHECKSUM_EN for the frame length.
module tb_flit_uart_sequencer;

`ifdef FLIT_UART_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        expSrc;
        logic [31:0] expWord;
        logic [7:0]  expCsum;
    } FrameVec;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_send_en;
    logic        tx_done;
    logic        busy;
    logic        cur_src;
    logic [3:0]  byte_idx;
    logic        timeout_err;

    int vectors;
    int miscompares;
    int launchCount;

    flit_uart_sequencer #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_byte     (tx_byte),
        .tx_send_en  (tx_send_en),
        .tx_done     (tx_done),
        .busy        (busy),
        .cur_src     (cur_src),
        .byte_idx    (byte_idx),
        .timeout_err (timeout_err)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every launch pulse the DUT issues
    always @(posedge clk) begin
        if (reset) begin
            launchCount <= 0;
        end else if (tx_send_en) begin
            launchCount <= launchCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and confirm the ready vector is never two-hot
    task automatic tick();
        @(negedge clk);
        vectors++;
        if (req_ready === 2'b11) begin
            miscompares++;
            $display("[TB] FAIL req_ready one-hot: got %b, expected at most one bit set", req_ready);
        end
    endtask

    task automatic waitAccept(output logic [1:0] acc);
        acc = 2'b00;
        #1;
        for (int i = 0; i < 50 && acc == 2'b00; i++) begin
            if ((req_valid & req_ready) != 2'b00) acc = req_valid & req_ready;
            else tick();
        end
        if (acc == 2'b00) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept wait: got no accept, expected one within 50 cycles");
        end
    endtask

    // Present one flit, then check every byte launch and answer each with tx_done
    task automatic applyStimulus(input FrameVec v, input int firstDelay, input bit spurious);
        logic [1:0]  acc;
        logic [7:0]  expByte;
        logic [31:0] w;
        int          waited;
        int          dly;
        req_valid = v.valid;
        req_data  = {v.d1, v.d0};
        waitAccept(acc);
        if (acc == 2'b00) return;
        checkOutput("grant source", {31'd0, acc[1]}, {31'd0, v.expSrc});
        tick();
        req_valid = req_valid & ~acc;
        w = v.expWord;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k < 4) expByte = w[31-8*k -: 8];
            else       expByte = v.expCsum;
            checkOutput("tx_send_en", {31'd0, tx_send_en}, 32'd1);
            checkOutput("tx_byte", {24'd0, tx_byte}, {24'd0, expByte});
            checkOutput("byte_idx", {28'd0, byte_idx}, k);
            checkOutput("cur_src", {31'd0, cur_src}, {31'd0, v.expSrc});
            checkOutput("busy in frame", {31'd0, busy}, 32'd1);
            waited = 0;
            if (k == 0 && spurious) begin
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
                waited = 1;
                checkOutput("spurious SEND byte_idx", {28'd0, byte_idx}, 32'd0);
                checkOutput("spurious SEND launch", {31'd0, tx_send_en}, 32'd0);
            end
            dly = (k == 0) ? firstDelay : 10;
            repeat (dly - waited) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        checkOutput("frame end busy", {31'd0, busy}, 32'd0);
        checkOutput("frame end send_en", {31'd0, tx_send_en}, 32'd0);
    endtask

    FrameVec   vecs[9];
    FrameVec   v;
    logic [1:0] acc;
    int         startLaunches;

    initial begin
        vectors     = 0;
        miscompares = 0;
        vecs[0] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hAAAAAAAA, 8'h00};
        vecs[1] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h55555555, 8'h00};
        vecs[2] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hAAAAAAAA, 8'h00};
        vecs[3] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h55555555, 8'h00};
        vecs[4] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hAAAAAAAA, 8'h00};
        vecs[5] = '{2'b10, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h55555555, 8'h00};
        vecs[6] = '{2'b01, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 8'h08};
        vecs[7] = '{2'b10, 32'h00000000, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 8'h22};
        vecs[8] = '{2'b10, 32'h00000000, 32'h0F1E2D4B, 1'b1, 32'h0F1E2D4B, 8'h77};

        reset     = 1'b1;
        req_valid = 2'b11;
        req_data  = {32'h55555555, 32'hAAAAAAAA};
        tx_done   = 1'b0;
        repeat (2) tick();
        checkOutput("reset req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("reset tx_byte", {24'd0, tx_byte}, 32'd0);
        checkOutput("reset tx_send_en", {31'd0, tx_send_en}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset cur_src", {31'd0, cur_src}, 32'd0);
        checkOutput("reset byte_idx", {28'd0, byte_idx}, 32'd0);
        checkOutput("reset timeout_err", {31'd0, timeout_err}, 32'd0);
        req_valid = 2'b00;
        reset     = 1'b0;
        tick();

        $display("[TB] table frames");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], 10, 1'b0);
        end

        $display("[TB] spurious tx_done in IDLE");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        checkOutput("idle spurious busy", {31'd0, busy}, 32'd0);
        checkOutput("idle spurious byte_idx", {28'd0, byte_idx}, FRAME_LEN - 1);
        checkOutput("idle spurious send_en", {31'd0, tx_send_en}, 32'd0);

        $display("[TB] done/expiry race with spurious tx_done in SEND");
        v = '{2'b10, 32'h00000000, 32'h01020304, 1'b1, 32'h01020304, 8'h04};
        applyStimulus(v, 21, 1'b1);
        checkOutput("race timeout_err", {31'd0, timeout_err}, 32'd0);

        $display("[TB] timeout");
        req_valid = 2'b01;
        req_data  = {32'h00000000, 32'hCAFEF00D};
        waitAccept(acc);
        checkOutput("timeout accept", {30'd0, acc}, 32'd1);
        startLaunches = launchCount;
        tick();
        req_valid = 2'b00;
        checkOutput("timeout byte0 launch", {31'd0, tx_send_en}, 32'd1);
        checkOutput("timeout byte0", {24'd0, tx_byte}, 32'hCA);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("timeout byte1 launch", {31'd0, tx_send_en}, 32'd1);
        checkOutput("timeout byte1", {24'd0, tx_byte}, 32'hFE);
        repeat (21) tick();
        checkOutput("timeout busy before expiry", {31'd0, busy}, 32'd1);
        checkOutput("timeout err before expiry", {31'd0, timeout_err}, 32'd0);
        tick();
        checkOutput("timeout busy after expiry", {31'd0, busy}, 32'd0);
        checkOutput("timeout err after expiry", {31'd0, timeout_err}, 32'd1);
        repeat (5) tick();
        checkOutput("timeout launches", launchCount - startLaunches, 32'd2);
        checkOutput("timeout tx_byte held", {24'd0, tx_byte}, 32'hFE);
        v = '{2'b01, 32'h0A0B0C0D, 32'h00000000, 1'b0, 32'h0A0B0C0D, 8'h00};
        applyStimulus(v, 10, 1'b0);
        checkOutput("timeout_err sticky", {31'd0, timeout_err}, 32'd1);

        $display("[TB] reset mid-frame");
        req_valid = 2'b01;
        req_data  = {32'h00000000, 32'h11223344};
        waitAccept(acc);
        tick();
        req_valid = 2'b00;
        checkOutput("mid byte0", {24'd0, tx_byte}, 32'h11);
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("mid byte1", {24'd0, tx_byte}, 32'h22);
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("mid byte2", {24'd0, tx_byte}, 32'h33);
        checkOutput("mid byte2 idx", {28'd0, byte_idx}, 32'd2);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid reset req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("mid reset tx_byte", {24'd0, tx_byte}, 32'd0);
        checkOutput("mid reset send_en", {31'd0, tx_send_en}, 32'd0);
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid reset byte_idx", {28'd0, byte_idx}, 32'd0);
        checkOutput("mid reset timeout_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();
        startLaunches = launchCount;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (5) tick();
        checkOutput("post reset launches", launchCount - startLaunches, 32'd0);
        checkOutput("post reset busy", {31'd0, busy}, 32'd0);
        checkOutput("post reset byte_idx", {28'd0, byte_idx}, 32'd0);

        $display("[TB] tie after reset goes to source 0");
        v = '{2'b11, 32'h5A000001, 32'h77777777, 1'b0, 32'h5A000001, 8'h5B};
        applyStimulus(v, 10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
